fetch_unit: RTL and testbench
=============================

# fetch_unit

Parametrised instruction-fetch stage for the pipelined RV32I core; it replaces the single-cycle PC register and ROM lookup path. It owns the PC, issues word requests to a synchronous-read instruction memory, buffers returned instructions in a QDEPTH-entry queue, and presents them to decode with a valid/ready handshake. It also handles redirects from execute and a terminal halt state.

## Interface
- XLEN, 32, PC and datapath width.
- RESET_PC, 0, PC loaded on reset; bits [1:0] must be 0.
- IMEM_AW, 6, instruction memory word-address width; address is PC[IMEM_AW+1:2].
- QDEPTH, 4, instruction queue depth; must be at least 2.
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- imem_req  out  1  read request this cycle.
- imem_addr  out  IMEM_AW  word address of the request.
- imem_rdata  in  32  instruction; valid in the cycle after imem_req; memory is always ready.
- redirect_valid  in  1  taken branch, jal or jalr resolved in execute.
- redirect_pc  in  XLEN  target; bits [1:0] ignored and treated as 0.
- halt  in  1  decode detected a halt instruction.
- id_ready  in  1  decode can accept; low means stall.
- id_valid  out  1  queue head is presented.
- id_instr  out  32  head instruction; 0 when id_valid=0.
- id_pc  out  XLEN  PC of the head instruction.
- id_pc4  out  XLEN  id_pc+4, modulo 2^XLEN.
- halted  out  1  unit is in the HALTED state.
- q_count  out  clog2(QDEPTH+1)  current queue occupancy.

## Operation
- FSM has two states.
  - RUN: the reset state.
  - HALTED: terminal; only reset leaves it.
- Request rule: in RUN, imem_req=1 when count + inflight < QDEPTH and no redirect or halt is asserted this cycle. On each request, fetch_pc advances by 4.
- inflight: registered; set to 1 in the cycle after a request and carries the request's PC.
- Response handling: if inflight=1 and the kill flag is clear, {imem_rdata, pc} is pushed into the queue at the end of that cycle.
- Pop: occurs on id_valid & id_ready. Push and pop in the same cycle are allowed at any occupancy, and count is unchanged.
- Redirect, in RUN:
  - queue is cleared;
  - fetch_pc is set to {redirect_pc[XLEN-1:2], 2'b00};
  - kill is set, so the response to any request issued in the previous cycle is dropped;
  - no request is issued in the redirect cycle.
- Halt: the FSM moves to HALTED. The queue is cleared, any in-flight response is dropped, and imem_req, id_valid and redirects are ignored thereafter.
- Simultaneous events:
  - halt together with redirect: halt wins.
  - redirect together with pop: the pop is discarded and the queue is cleared.
- PC arithmetic is modulo 2^XLEN. Wrap from 0xFFFFFFFC to 0 is legal.

## Timing
- Reset values:
  - fetch_pc=RESET_PC, queue empty, inflight=0, kill=0, state=RUN;
  - imem_req=0, id_valid=0, id_instr=0, id_pc=0, id_pc4=0, halted=0, q_count=0.
- First request is in the first clock edge after reset deasserts.
- Fetch latency: request in cycle N, data in N+1, queue push at end of N+1, id_valid in N+2.
- Redirect in cycle R: first request at the target in R+1, target presented on id_valid in R+3.
- Steady state with id_ready held high: one instruction per cycle after the initial 2-cycle fill.
- Stall: the id_* outputs hold stable while id_valid=1 and id_ready=0. Requests stop once count + inflight = QDEPTH.
- halted asserts in the cycle after halt is sampled.
- Reset mid-operation: every output returns to its reset value asynchronously, and any in-flight response is never pushed.

## Structure
- Shared package riscv_core_pkg:
  - XLEN default;
  - fetch FSM state encoding (RUN, HALTED);
  - NOP constant 32'h00000013, used by the downstream bubble insertion.
- Sub-module fetch_queue:
  - parametrised synchronous FIFO (WIDTH, DEPTH);
  - push, pop, flush, count, head;
  - registered read pointer;
  - fetch_unit instantiates it with WIDTH = 32 + XLEN.

## Test plan
- Reset with RESET_PC=0 and id_ready=1. Required: imem_addr 0,1,2,… on successive cycles; id_valid first high 2 cycles after the first request; id_pc 0,4,8 with id_pc4 4,8,12.
- id_ready=0 for 10 cycles. Required: q_count saturates at 4; imem_req stays low while count + inflight = 4; id_pc stays constant.
- Redirect to 0x40 while 3 entries are queued and one request is in flight. Required: queue cleared; stale response dropped; next id_pc is 0x40, exactly 3 cycles later.
- Redirect to 0x43. Required: id_pc = 0x40.
- halt and redirect in the same cycle. Required: halted=1 next cycle; no further imem_req or id_valid until reset.
- fetch_pc reaches 0xFFFFFFFC with XLEN=32. Required: next id_pc = 0x00000000.
- Assert reset mid-stream with the queue full. Required: all outputs go to reset values asynchronously; refetch begins at RESET_PC.

Source files
------------

// File: rtl/riscv_core_pkg.sv
// Shared definitions for the RV32I pipeline: datapath width, fetch FSM
// encoding and the canonical NOP used for bubble insertion.
package riscv_core_pkg;

  localparam int XLEN = 32;

  typedef enum logic [0:0] {
    FETCH_RUN    = 1'b0,
    FETCH_HALTED = 1'b1
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO between instruction memory and decode. Push and pop may
// share a cycle at any occupancy; flush discards everything.
module fetch_queue #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [WIDTH-1:0]           head
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             push_s, pop_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? {PW{1'b0}} : p + PW'(1);
  endfunction

  assign pop_s  = pop & (count_r != {CW{1'b0}});
  // A full queue still accepts a push when its head leaves in the same cycle.
  assign push_s = push & ((count_r != CNT_FULL) | pop_s);
  assign count  = count_r;
  assign head   = mem_r[rd_ptr_r];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      wr_ptr_r <= push_s ? ptr_inc(wr_ptr_r) : wr_ptr_r;
      rd_ptr_r <= pop_s ? ptr_inc(rd_ptr_r) : rd_ptr_r;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage
  always_ff @(posedge clk) begin
    if (push_s && !flush) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word reads to a synchronous
// instruction memory and hands queued instructions to decode.
module fetch_unit #(
  parameter int              XLEN     = riscv_core_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}},
  parameter int              IMEM_AW  = 6,
  parameter int              QDEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  output logic                        imem_req,
  output logic [IMEM_AW-1:0]          imem_addr,
  input  logic [31:0]                 imem_rdata,
  input  logic                        redirect_valid,
  input  logic [XLEN-1:0]             redirect_pc,
  input  logic                        halt,
  input  logic                        id_ready,
  output logic                        id_valid,
  output logic [31:0]                 id_instr,
  output logic [XLEN-1:0]             id_pc,
  output logic [XLEN-1:0]             id_pc4,
  output logic                        halted,
  output logic [$clog2(QDEPTH+1)-1:0] q_count
);

  import riscv_core_pkg::*;

  localparam int CW = $clog2(QDEPTH + 1);
  localparam int QW = 32 + XLEN;
  localparam logic [XLEN-1:0] PC_STEP  = {{(XLEN-3){1'b0}}, 3'b100};
  localparam logic [CW:0]     OCC_FULL = (CW+1)'(QDEPTH);

  fetch_state_e    state_r, state_nxt_s;
  logic [XLEN-1:0] fetch_pc_r, inflight_pc_r;
  logic            inflight_r, kill_r;
  logic            run_s, halt_s, redirect_s, flush_s;
  logic            req_s, push_s, pop_s, id_valid_s;
  logic [CW:0]     occupancy_s;
  logic [QW-1:0]   head_s;
  logic            unused_s;

  assign run_s       = (state_r == FETCH_RUN);
  assign halt_s      = run_s & halt;
  assign redirect_s  = run_s & redirect_valid & ~halt;
  assign flush_s     = halt_s | redirect_s;
  assign occupancy_s = {1'b0, q_count} + {{CW{1'b0}}, inflight_r};
  // Reset gates the request combinationally so imem_req is low while held.
  assign req_s       = ~reset & run_s & ~redirect_valid & ~halt & (occupancy_s < OCC_FULL);
  assign push_s      = run_s & inflight_r & ~kill_r;
  assign id_valid_s  = run_s & (q_count != {CW{1'b0}});
  assign pop_s       = id_valid_s & id_ready;
  assign unused_s    = ^redirect_pc[1:0];

  fetch_queue #(
    .WIDTH (QW),
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .push_data ({imem_rdata, inflight_pc_r}),
    .pop       (pop_s),
    .flush     (flush_s),
    .count     (q_count),
    .head      (head_s)
  );

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= FETCH_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: HALTED is left only through reset
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      FETCH_RUN: begin
        if (halt) begin
          state_nxt_s = FETCH_HALTED;
        end else begin
          state_nxt_s = FETCH_RUN;
        end
      end
      FETCH_HALTED: state_nxt_s = FETCH_HALTED;
      default:      state_nxt_s = FETCH_RUN;
    endcase
  end

  // FSM outputs and decode-facing view of the queue head
  always_comb begin
    halted    = 1'b0;
    imem_req  = 1'b0;
    imem_addr = fetch_pc_r[IMEM_AW+1:2];
    id_valid  = 1'b0;
    id_instr  = 32'h0000_0000;
    id_pc     = {XLEN{1'b0}};
    id_pc4    = {XLEN{1'b0}};
    case (state_r)
      FETCH_RUN: begin
        imem_req = req_s;
        id_valid = id_valid_s;
        if (id_valid_s) begin
          id_instr = head_s[QW-1:XLEN];
          id_pc    = head_s[XLEN-1:0];
          id_pc4   = head_s[XLEN-1:0] + PC_STEP;
        end else begin
          id_instr = 32'h0000_0000;
          id_pc    = {XLEN{1'b0}};
          id_pc4   = {XLEN{1'b0}};
        end
      end
      FETCH_HALTED: halted = 1'b1;
      default:      halted = 1'b0;
    endcase
  end

  // PC, in-flight request tracking and response kill flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_r    <= RESET_PC;
      inflight_r    <= 1'b0;
      inflight_pc_r <= {XLEN{1'b0}};
      kill_r        <= 1'b0;
    end else begin
      if (redirect_s) begin
        fetch_pc_r <= {redirect_pc[XLEN-1:2], 2'b00};
      end else if (req_s) begin
        fetch_pc_r <= fetch_pc_r + PC_STEP;
      end else begin
        fetch_pc_r <= fetch_pc_r;
      end
      inflight_r    <= req_s;
      inflight_pc_r <= req_s ? fetch_pc_r : inflight_pc_r;
      kill_r        <= flush_s;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized
// stream checked against a PC-sequence reference model.
module tb_fetch_unit;

  localparam int XLEN    = 32;
  localparam int IMEM_AW = 6;
  localparam int QDEPTH  = 4;
  localparam int CW      = $clog2(QDEPTH + 1);

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               imem_req;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_rdata;
  logic               redirect_valid = 1'b0;
  logic [XLEN-1:0]    redirect_pc = 32'h0;
  logic               halt = 1'b0;
  logic               id_ready = 1'b1;
  logic               id_valid;
  logic [31:0]        id_instr;
  logic [XLEN-1:0]    id_pc, id_pc4;
  logic               halted;
  logic [CW-1:0]      q_count;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0]        imem [0:(1<<IMEM_AW)-1];
  logic [IMEM_AW-1:0] mem_addr_q = '0;

  always #5 clk = ~clk;

  // Synchronous-read instruction memory, always ready
  always @(posedge clk) if (imem_req) mem_addr_q <= imem_addr;
  assign imem_rdata = imem[mem_addr_q];

  fetch_unit #(
    .XLEN(XLEN), .RESET_PC(32'h0), .IMEM_AW(IMEM_AW), .QDEPTH(QDEPTH)
  ) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .halt(halt), .id_ready(id_ready),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_pc4(id_pc4),
    .halted(halted), .q_count(q_count)
  );

  function automatic logic [31:0] instr_at(input logic [31:0] pc);
    return imem[pc[IMEM_AW+1:2]];
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; id_ready = 1'b1; redirect_valid = 1'b0; halt = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    vectors++;
    if ({imem_req, id_valid, id_instr, id_pc, id_pc4, halted, q_count} !== '0)
      begin miscompares++; $display("FAIL reset_outputs: got %h, expected 0",
        {imem_req, id_valid, id_instr, id_pc, id_pc4, halted, q_count}); end
  endtask

  task automatic test_stream();
    next_cycle();
    reset = 1'b0;
    #1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin next_cycle(); #1; end
      vectors++;
      if (imem_req !== 1'b1 || imem_addr !== 6'(k)) begin miscompares++;
        $display("FAIL stream_req: got req=%b addr=%0d, expected req=1 addr=%0d", imem_req, imem_addr, k); end
      vectors++;
      if (k < 2) begin
        if (id_valid !== 1'b0) begin miscompares++;
          $display("FAIL stream_fill: got id_valid=%b at cycle %0d, expected 0", id_valid, k); end
      end else if (id_valid !== 1'b1 || id_pc !== 32'(4*(k-2)) || id_pc4 !== 32'(4*(k-1))
                   || id_instr !== instr_at(32'(4*(k-2)))) begin
        miscompares++;
        $display("FAIL stream_out: got v=%b pc=%h pc4=%h instr=%h, expected v=1 pc=%h pc4=%h instr=%h",
                 id_valid, id_pc, id_pc4, id_instr, 32'(4*(k-2)), 32'(4*(k-1)), instr_at(32'(4*(k-2))));
      end
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      id_ready = 1'b0;
      #1;
      vectors++;
      if (id_valid !== 1'b1 || id_pc !== 32'h10 || id_instr !== instr_at(32'h10)) begin miscompares++;
        $display("FAIL stall_hold: got v=%b pc=%h instr=%h, expected v=1 pc=00000010 instr=%h",
                 id_valid, id_pc, id_instr, instr_at(32'h10)); end
      if (i >= 2) begin
        vectors++;
        if (imem_req !== 1'b0) begin miscompares++;
          $display("FAIL stall_req: got imem_req=%b at stall cycle %0d, expected 0", imem_req, i); end
      end
    end
    vectors++;
    if (q_count !== 3'd4) begin miscompares++;
      $display("FAIL stall_count: got %0d, expected 4", q_count); end
  endtask

  task automatic test_redirect();
    next_cycle(); id_ready = 1'b1; #1;
    vectors++;
    if (imem_req !== 1'b0 || id_pc !== 32'h10) begin miscompares++;
      $display("FAIL redir_pre_a: got req=%b pc=%h, expected req=0 pc=00000010", imem_req, id_pc); end
    next_cycle(); id_ready = 1'b0; #1;
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 6'd8 || q_count !== 3'd3) begin miscompares++;
      $display("FAIL redir_pre_b: got req=%b addr=%0d cnt=%0d, expected req=1 addr=8 cnt=3", imem_req, imem_addr, q_count); end
    next_cycle(); redirect_valid = 1'b1; redirect_pc = 32'h40; #1;
    vectors++;
    if (imem_req !== 1'b0 || q_count !== 3'd3) begin miscompares++;
      $display("FAIL redir_cycle: got req=%b cnt=%0d, expected req=0 cnt=3", imem_req, q_count); end
    next_cycle(); redirect_valid = 1'b0; id_ready = 1'b1; #1;
    vectors++;
    if (q_count !== 3'd0 || id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 6'h10) begin miscompares++;
      $display("FAIL redir_r1: got cnt=%0d v=%b req=%b addr=%h, expected cnt=0 v=0 req=1 addr=10", q_count, id_valid, imem_req, imem_addr); end
    next_cycle(); #1;
    vectors++;
    if (q_count !== 3'd0 || id_valid !== 1'b0) begin miscompares++;
      $display("FAIL redir_r2: got cnt=%0d v=%b, expected cnt=0 v=0 (stale drop)", q_count, id_valid); end
    next_cycle(); #1;
    vectors++;
    if (id_valid !== 1'b1 || id_pc !== 32'h40 || id_instr !== instr_at(32'h40)) begin miscompares++;
      $display("FAIL redir_r3: got v=%b pc=%h instr=%h, expected v=1 pc=00000040 instr=%h", id_valid, id_pc, id_instr, instr_at(32'h40)); end
  endtask

  task automatic test_redirect_unaligned();
    next_cycle(); redirect_valid = 1'b1; redirect_pc = 32'h43; #1;
    next_cycle(); redirect_valid = 1'b0; #1;
    next_cycle(); #1;
    next_cycle(); #1;
    vectors++;
    if (id_valid !== 1'b1 || id_pc !== 32'h40 || id_pc4 !== 32'h44) begin miscompares++;
      $display("FAIL redir_unaligned: got v=%b pc=%h pc4=%h, expected v=1 pc=00000040 pc4=00000044", id_valid, id_pc, id_pc4); end
    next_cycle(); #1;
    vectors++;
    if (id_pc !== 32'h44 || id_instr !== instr_at(32'h44)) begin miscompares++;
      $display("FAIL redir_unaligned_next: got pc=%h, expected 00000044", id_pc); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc;
    next_cycle(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8; #1;
    next_cycle(); redirect_valid = 1'b0; #1;
    next_cycle(); #1;
    exp_pc = 32'hFFFF_FFF8;
    for (int i = 0; i < 3; i++) begin
      next_cycle(); #1;
      vectors++;
      if (id_valid !== 1'b1 || id_pc !== exp_pc || id_pc4 !== exp_pc + 32'd4 || id_instr !== instr_at(exp_pc)) begin
        miscompares++;
        $display("FAIL wrap: got v=%b pc=%h pc4=%h, expected v=1 pc=%h pc4=%h", id_valid, id_pc, id_pc4, exp_pc, exp_pc + 32'd4);
      end
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_next, tgt;
    logic        rdy, rd;
    int          idle;
    exp_next = 32'h0;
    idle = 0;
    for (int c = 0; c < 400; c++) begin
      next_cycle();
      rdy = ($urandom_range(0, 3) != 0);
      rd  = (c == 0) || ($urandom_range(0, 15) == 0);
      tgt = $urandom;
      id_ready = rdy; redirect_valid = rd; redirect_pc = tgt; halt = 1'b0;
      #1;
      vectors++;
      if (q_count > 3'(QDEPTH)) begin miscompares++;
        $display("FAIL rand_count: got %0d, expected <= %0d", q_count, QDEPTH); end
      if (id_valid && c > 0) begin
        vectors++;
        if (id_pc !== exp_next || id_pc4 !== exp_next + 32'd4 || id_instr !== instr_at(exp_next)) begin
          miscompares++;
          $display("FAIL rand_stream: got pc=%h pc4=%h instr=%h, expected pc=%h pc4=%h instr=%h",
                   id_pc, id_pc4, id_instr, exp_next, exp_next + 32'd4, instr_at(exp_next));
        end
        idle = 0;
      end else if (!id_valid && rdy) begin
        idle++;
        vectors++;
        if (idle > 4) begin miscompares++;
          $display("FAIL rand_starve: got %0d idle ready cycles, expected <= 4", idle); end
      end
      if (rd) begin
        exp_next = {tgt[31:2], 2'b00};
        idle = 0;
      end else if (id_valid && rdy) begin
        exp_next = exp_next + 32'd4;
      end
    end
    next_cycle(); redirect_valid = 1'b0; #1;
  endtask

  task automatic test_halt();
    next_cycle(); halt = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80; id_ready = 1'b1; #1;
    next_cycle(); halt = 1'b0; redirect_valid = 1'b0; #1;
    vectors++;
    if (halted !== 1'b1 || imem_req !== 1'b0 || id_valid !== 1'b0 || q_count !== 3'd0 || id_instr !== 32'h0) begin
      miscompares++;
      $display("FAIL halt_enter: got halted=%b req=%b v=%b cnt=%0d instr=%h, expected 1 0 0 0 0",
               halted, imem_req, id_valid, q_count, id_instr);
    end
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      redirect_valid = $urandom_range(0, 1); redirect_pc = $urandom; id_ready = $urandom_range(0, 1);
      #1;
      vectors++;
      if (halted !== 1'b1 || imem_req !== 1'b0 || id_valid !== 1'b0) begin miscompares++;
        $display("FAIL halt_hold: got halted=%b req=%b v=%b, expected 1 0 0", halted, imem_req, id_valid); end
    end
  endtask

  task automatic test_reset_mid();
    next_cycle(); reset = 1'b1; redirect_valid = 1'b0; id_ready = 1'b0;
    next_cycle(); reset = 1'b0; #1;
    for (int i = 0; i < 8; i++) next_cycle();
    #1;
    vectors++;
    if (q_count !== 3'd4 || id_valid !== 1'b1 || id_pc !== 32'h0) begin miscompares++;
      $display("FAIL rmid_full: got cnt=%0d v=%b pc=%h, expected cnt=4 v=1 pc=0", q_count, id_valid, id_pc); end
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if ({imem_req, id_valid, id_instr, id_pc, id_pc4, halted, q_count} !== '0) begin miscompares++;
      $display("FAIL rmid_async: got %h, expected 0", {imem_req, id_valid, id_instr, id_pc, id_pc4, halted, q_count}); end
    next_cycle(); reset = 1'b0; id_ready = 1'b1; #1;
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 6'd0 || q_count !== 3'd0) begin miscompares++;
      $display("FAIL rmid_refetch: got req=%b addr=%0d cnt=%0d, expected req=1 addr=0 cnt=0", imem_req, imem_addr, q_count); end
    next_cycle(); next_cycle(); #1;
    vectors++;
    if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== instr_at(32'h0)) begin miscompares++;
      $display("FAIL rmid_first: got v=%b pc=%h, expected v=1 pc=00000000", id_valid, id_pc); end
  endtask

  initial begin
    for (int i = 0; i < (1 << IMEM_AW); i++) imem[i] = $urandom;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_unaligned();
    test_wrap();
    test_random();
    test_halt();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
